riscv_multicycle_control: RTL and testbench

Multi-cycle successor to the combinational RISC-V control decoder. It accepts one instruction's opcode/funct3/funct7 through a valid/ready handshake and sequences it through DECODE, EXECUTE, MEM and WRITEBACK. It drives alu_control, regwrite_control, memory strobes and pc_write, and flags illegal encodings. It sits between the instruction-fetch stage and the datapath register file, ALU and data memory.

---
 rtl/riscv_multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_riscv_multicycle_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_multicycle_control
//  Brief    : Multi-cycle RISC-V control sequencer. Takes one instruction's
//             opcode/funct3/funct7 through a valid/ready handshake and walks it
//             through DECODE, EXECUTE, MEM and WRITEBACK. It drives the ALU
//             select, register-file write, memory strobes and PC advance, and
//             raises a trap pulse on illegal encodings or memory timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_multicycle_control #(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  mem_done,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  regwrite_control,
    output logic                  memread,
    output logic                  memwrite,
    output logic                  pc_write,
    output logic                  illegal_instr,
    output logic [CNT_W-1:0]      retired_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRL = 4'd6, ALU_SRA = 4'd7;

    // Timeout counter only ever holds 0..MEM_TIMEOUT-1 before the trap fires.
    localparam int              TO_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        opcode_q, funct7_q;
    logic [2:0]        funct3_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic              dec_legal, dec_is_load, dec_is_store;
    logic [3:0]        dec_alu;
    logic              store_retire;

    // funct3 -> ALU code for the non-alternate arithmetic forms
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    return 4'd0;   // ADD
            3'd1:    return 4'd2;   // SLL
            3'd2:    return 4'd3;   // SLT
            3'd3:    return 4'd4;   // SLTU
            3'd4:    return 4'd5;   // XOR
            3'd5:    return 4'd6;   // SRL
            3'd6:    return 4'd8;   // OR
            default: return 4'd9;   // AND
        endcase
    endfunction

    // Classify the captured instruction fields
    always_comb begin
        dec_legal    = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_alu      = ALU_ADD;
        case (opcode_q)
            OP_R: begin
                if (funct7_q == F7_ZERO) begin
                    dec_legal = 1'b1;
                    dec_alu   = base_alu(funct3_q);
                end else if (funct7_q == F7_ALT) begin
                    if (funct3_q == 3'd0) begin
                        dec_legal = 1'b1;
                        dec_alu   = ALU_SUB;
                    end else if (funct3_q == 3'd5) begin
                        dec_legal = 1'b1;
                        dec_alu   = ALU_SRA;
                    end
                end
            end
            OP_I: begin
                case (funct3_q)
                    3'd1: begin
                        dec_legal = (funct7_q == F7_ZERO);
                        dec_alu   = base_alu(funct3_q);
                    end
                    3'd5: begin
                        dec_legal = (funct7_q == F7_ZERO) || (funct7_q == F7_ALT);
                        dec_alu   = (funct7_q == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_alu   = base_alu(funct3_q);
                    end
                endcase
            end
            OP_LOAD: begin
                dec_legal   = funct3_q inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                dec_is_load = 1'b1;
            end
            OP_STORE: begin
                dec_legal    = funct3_q inside {3'd0, 3'd1, 3'd2};
                dec_is_store = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state selection; a completed store retires directly out of MEM
    always_comb begin
        state_d      = state_q;
        store_retire = 1'b0;
        case (state_q)
            S_IDLE:    if (instr_valid) state_d = S_DECODE;
            S_DECODE:  state_d = dec_legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: state_d = (dec_is_load || dec_is_store) ? S_MEM : S_WRITEBACK;
            S_MEM: begin
                // mem_done takes priority over an expiring timeout
                if (mem_done) begin
                    if (dec_is_load) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d      = S_IDLE;
                        store_retire = 1'b1;
                    end
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: state_d = S_IDLE;
            S_TRAP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State, captured fields, counters and registered outputs (decoded from next state)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            opcode_q         <= '0;
            funct3_q         <= '0;
            funct7_q         <= '0;
            to_cnt_q         <= '0;
            retired_count    <= '0;
            instr_ready      <= 1'b1;
            alu_control      <= '0;
            regwrite_control <= 1'b0;
            memread          <= 1'b0;
            memwrite         <= 1'b0;
            pc_write         <= 1'b0;
            illegal_instr    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && instr_valid) begin
                opcode_q <= opcode;
                funct3_q <= funct3;
                funct7_q <= funct7;
            end
            if (state_q == S_EXECUTE) begin
                to_cnt_q <= '0;
            end else if (state_q == S_MEM && !mem_done) begin
                to_cnt_q <= to_cnt_q + TO_ONE;
            end
            if (state_q == S_WRITEBACK || store_retire) begin
                retired_count <= retired_count + CNT_ONE;
            end
            instr_ready      <= (state_d == S_IDLE);
            alu_control      <= (state_d == S_EXECUTE || state_d == S_MEM || state_d == S_WRITEBACK)
                                ? ALU_CTRL_W'(dec_alu) : '0;
            regwrite_control <= (state_d == S_WRITEBACK);
            memread          <= (state_d == S_MEM) && dec_is_load;
            memwrite         <= (state_d == S_MEM) && dec_is_store;
            pc_write         <= (state_d == S_WRITEBACK) || store_retire;
            illegal_instr    <= (state_d == S_TRAP);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_multicycle_control
//  Brief    : Self-checking bench for riscv_multicycle_control. Directed cases
//             plus randomized instructions, compared cycle by cycle against a
//             timeline built from an instruction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_control;

    localparam int ALU_W = 5;
    localparam int TO    = 4;
    localparam int CW    = 2;

    logic             clk;
    logic             reset;
    logic             instr_valid;
    logic             instr_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             mem_done;
    logic [ALU_W-1:0] alu_control;
    logic             regwrite_control;
    logic             memread;
    logic             memwrite;
    logic             pc_write;
    logic             illegal_instr;
    logic [CW-1:0]    retired_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    riscv_multicycle_control #(
        .ALU_CTRL_W (ALU_W),
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .mem_done        (mem_done),
        .alu_control     (alu_control),
        .regwrite_control(regwrite_control),
        .memread         (memread),
        .memwrite        (memwrite),
        .pc_write        (pc_write),
        .illegal_instr   (illegal_instr),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output snapshot: {ready, alu, regwrite, memread, memwrite, pc_write, illegal, count}
    function automatic logic [31:0] pk(input logic rdy, input int alu, input logic rw, input logic mr,
                                       input logic mw, input logic pcw, input logic ill, input int cnt);
        logic [ALU_W-1:0] a;
        logic [CW-1:0]    c;
        a = ALU_W'(alu);
        c = CW'(cnt);
        return {19'b0, rdy, a, rw, mr, mw, pcw, ill, c};
    endfunction

    function automatic logic [31:0] observed();
        return {19'b0, instr_ready, alu_control, regwrite_control, memread, memwrite,
                pc_write, illegal_instr, retired_count};
    endfunction

    // Instruction-level reference: kind 0 = ALU op, 1 = load, 2 = store
    task automatic ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              output bit legal, output int kind, output int alu);
        int amap [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        legal = 0; kind = 0; alu = 0;
        if (op == 7'b0110011) begin
            if (f7 == 7'h00) begin legal = 1; alu = amap[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; alu = 1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1; alu = 7; end
        end else if (op == 7'b0010011) begin
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else legal = 1;
            alu = (f3 == 3'd5 && f7 == 7'h20) ? 7 : amap[f3];
        end else if (op == 7'b0000011) begin
            kind = 1;
            legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        end else if (op == 7'b0100011) begin
            kind = 2;
            legal = (f3 <= 2);
        end
    endtask

    // Issue one instruction from IDLE (called at a negedge) and check every cycle
    // until the block is ready again. k = MEM cycle on which mem_done is given.
    task automatic run_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int k);
        logic [31:0] exp [16];
        bit legal;
        int kind, alu, last, lo, hi, n;
        ref_decode(op, f3, f7, legal, kind, alu);
        lo = 1; hi = 0;
        exp[1] = pk(0, 0, 0, 0, 0, 0, 0, exp_cnt);
        if (!legal) begin
            exp[2] = pk(0, 0, 0, 0, 0, 0, 1, exp_cnt);
            exp[3] = pk(1, 0, 0, 0, 0, 0, 0, exp_cnt);
            last = 3;
        end else if (kind == 0) begin
            exp[2] = pk(0, alu, 0, 0, 0, 0, 0, exp_cnt);
            exp[3] = pk(0, alu, 1, 0, 0, 1, 0, exp_cnt);
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            exp[4] = pk(1, 0, 0, 0, 0, 0, 0, exp_cnt);
            last = 4;
        end else begin
            n = (k <= TO) ? k : TO;
            lo = 3; hi = 2 + n;
            exp[2] = pk(0, 0, 0, 0, 0, 0, 0, exp_cnt);
            for (int j = 1; j <= n; j++)
                exp[2 + j] = pk(0, 0, 0, kind == 1, kind == 2, 0, 0, exp_cnt);
            if (k > TO) begin
                exp[3 + TO] = pk(0, 0, 0, 0, 0, 0, 1, exp_cnt);
                exp[4 + TO] = pk(1, 0, 0, 0, 0, 0, 0, exp_cnt);
                last = 4 + TO;
            end else if (kind == 1) begin
                exp[3 + k] = pk(0, 0, 1, 0, 0, 1, 0, exp_cnt);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                exp[4 + k] = pk(1, 0, 0, 0, 0, 0, 0, exp_cnt);
                last = 4 + k;
            end else begin
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                exp[3 + k] = pk(1, 0, 0, 0, 0, 1, 0, exp_cnt);
                last = 3 + k;
            end
        end
        instr_valid = 1'b1;
        opcode = op; funct3 = f3; funct7 = f7;
        mem_done = 1'($urandom);
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("%s c%0d", tag, c), observed(), exp[c]);
            if (c < last) begin
                // busy-state noise on the request side must be ignored
                instr_valid = 1'($urandom);
                opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            end else begin
                instr_valid = 1'b0;
            end
            if (c >= lo && c <= hi) mem_done = (c == 2 + k);
            else                    mem_done = 1'($urandom);
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; mem_done = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset", observed(), pk(1, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        run_txn("add",        7'b0110011, 3'd0, 7'h00, 1);
        run_txn("sub",        7'b0110011, 3'd0, 7'h20, 1);
        run_txn("r_bad_f7",   7'b0110011, 3'd2, 7'h7f, 1);
        run_txn("lw_wait",    7'b0000011, 3'd2, 7'h00, 3);
        run_txn("sb_timeout", 7'b0100011, 3'd0, 7'h00, 9);
        run_txn("sb_last",    7'b0100011, 3'd0, 7'h00, 4);
        run_txn("srai",       7'b0010011, 3'd5, 7'h20, 1);
        run_txn("slli_bad",   7'b0010011, 3'd1, 7'h20, 1);
        run_txn("ld_bad_f3",  7'b0000011, 3'd3, 7'h00, 1);
        run_txn("st_bad_f3",  7'b0100011, 3'd4, 7'h00, 1);
        run_txn("bad_op",     7'b1100011, 3'd0, 7'h00, 1);

        for (int t = 0; t < 80; t++) begin
            logic [6:0] op, f7;
            logic [2:0] f3;
            case ($urandom % 5)
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                default: op = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            case ($urandom % 3)
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            run_txn($sformatf("rnd%0d", t), op, f3, f7, int'($urandom_range(1, 6)));
        end

        // Reset during the second MEM cycle of a load aborts it
        instr_valid = 1'b1;
        opcode = 7'b0000011; funct3 = 3'd2; funct7 = 7'h00;
        mem_done = 1'b0;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre_reset_mem", observed(), pk(0, 0, 0, 1, 0, 0, 0, exp_cnt));
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("reset_in_mem", observed(), pk(1, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        exp_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            mem_done = 1'($urandom);
            @(posedge clk); @(negedge clk);
            check_eq($sformatf("post_reset_idle%0d", c), observed(), pk(1, 0, 0, 0, 0, 0, 0, 0));
        end
        mem_done = 1'b0;
        run_txn("after_reset_and", 7'b0110011, 3'd7, 7'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
